// File: rtl/rs_dec_error_locator.sv
// Single-error locator for the C1 RS(32,28) decoder: classifies a frame from its syndromes and
// runs a Chien-style search for the error byte. Optional counters are enabled by RS_DEC_STATS_EN.
module rs_dec_error_locator #(
    parameter int unsigned N       = 32,
    parameter logic [8:0]  GF_POLY = 9'h11D
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_start,
    input  logic [7:0] i_s0,
    input  logic [7:0] i_s1,
    input  logic [7:0] i_s2,
    input  logic [7:0] i_s3,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_no_error,
    output logic       o_corrected,
    output logic       o_uncorrectable,
    output logic [4:0] o_pos,
    output logic [7:0] o_mag,
    output logic       o_overrun
`ifdef RS_DEC_STATS_EN
    ,
    input  logic        i_cnt_clr,
    output logic [15:0] o_cnt_corr,
    output logic [15:0] o_cnt_unc
`endif
);

    localparam int unsigned DW    = 5;
    localparam int unsigned SW    = 8;
    localparam logic [SW-1:0] RED = GF_POLY[SW-1:0];
    localparam logic [DW-1:0] DMAX = DW'(N - 1);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] d_q, d_d;
    logic [SW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d, s0_q, s0_d;
    logic          busy_d, done_d, none_d, corr_d, unc_d, ovr_d;
    logic [DW-1:0] pos_d;
    logic [SW-1:0] mag_d;
    logic          is_none, is_unc0, is_match;

    function automatic logic [SW-1:0] mul_a(input logic [SW-1:0] v);
        return {v[SW-2:0], 1'b0} ^ (v[SW-1] ? RED : SW'(0));
    endfunction

    // s_j = e*a^(j*k): scaling x by a^3, y by a^2, z by a per step makes all four equal e*a^(3k) at d == k
    assign is_none  = (d_q == '0) && (x_q == '0) && (y_q == '0) && (z_q == '0) && (w_q == '0);
    assign is_unc0  = (d_q == '0) && (x_q == '0) && !is_none;
    assign is_match = (x_q != '0) && (x_q == y_q) && (y_q == z_q) && (z_q == w_q);

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        w_d     = w_q;
        s0_d    = s0_q;
        busy_d  = o_busy;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        none_d  = o_no_error;
        corr_d  = o_corrected;
        unc_d   = o_uncorrectable;
        pos_d   = o_pos;
        mag_d   = o_mag;
        if (i_start) begin
            // a new frame always wins, including over a decision made this cycle
            x_d     = i_s0;
            y_d     = i_s1;
            z_d     = i_s2;
            w_d     = i_s3;
            s0_d    = i_s0;
            d_d     = '0;
            state_d = SEARCH;
            busy_d  = 1'b1;
            ovr_d   = (state_q == SEARCH);
        end else if (state_q == SEARCH) begin
            if (is_none || is_unc0 || is_match || (d_q == DMAX)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                none_d  = is_none;
                corr_d  = !is_none && !is_unc0 && is_match;
                unc_d   = !is_none && (is_unc0 || !is_match);
                pos_d   = corr_d ? (DMAX - d_q) : '0;
                mag_d   = corr_d ? s0_q : '0;
            end else begin
                x_d = mul_a(mul_a(mul_a(x_q)));
                y_d = mul_a(mul_a(y_q));
                z_d = mul_a(z_q);
                d_d = d_q + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q         <= IDLE;
            d_q             <= '0;
            x_q             <= '0;
            y_q             <= '0;
            z_q             <= '0;
            w_q             <= '0;
            s0_q            <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_no_error      <= 1'b0;
            o_corrected     <= 1'b0;
            o_uncorrectable <= 1'b0;
            o_pos           <= '0;
            o_mag           <= '0;
            o_overrun       <= 1'b0;
        end else begin
            state_q         <= state_d;
            d_q             <= d_d;
            x_q             <= x_d;
            y_q             <= y_d;
            z_q             <= z_d;
            w_q             <= w_d;
            s0_q            <= s0_d;
            o_busy          <= busy_d;
            o_done          <= done_d;
            o_no_error      <= none_d;
            o_corrected     <= corr_d;
            o_uncorrectable <= unc_d;
            o_pos           <= pos_d;
            o_mag           <= mag_d;
            o_overrun       <= ovr_d;
        end
    end

`ifdef RS_DEC_STATS_EN
    localparam int unsigned CW = 16;

    // saturating frame counters; a clear pulse overrides a coincident increment
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            o_cnt_corr <= '0;
            o_cnt_unc  <= '0;
        end else if (i_cnt_clr) begin
            o_cnt_corr <= '0;
            o_cnt_unc  <= '0;
        end else if (done_d) begin
            if (corr_d && (o_cnt_corr != '1)) o_cnt_corr <= o_cnt_corr + CW'(1);
            if (unc_d && (o_cnt_unc != '1))   o_cnt_unc  <= o_cnt_unc + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rs_dec_error_locator.sv
// Directed bench for rs_dec_error_locator; covers the counters when RS_DEC_STATS_EN is defined.
module tb_rs_dec_error_locator;

    logic       i_clk = 1'b0;
    logic       i_res;
    logic       i_start;
    logic [7:0] i_s0, i_s1, i_s2, i_s3;
    logic       o_busy, o_done, o_no_error, o_corrected, o_uncorrectable, o_overrun;
    logic [4:0] o_pos;
    logic [7:0] o_mag;
`ifdef RS_DEC_STATS_EN
    logic        i_cnt_clr;
    logic [15:0] o_cnt_corr, o_cnt_unc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    rs_dec_error_locator dut (
        .i_clk(i_clk), .i_res(i_res), .i_start(i_start),
        .i_s0(i_s0), .i_s1(i_s1), .i_s2(i_s2), .i_s3(i_s3),
        .o_busy(o_busy), .o_done(o_done), .o_no_error(o_no_error),
        .o_corrected(o_corrected), .o_uncorrectable(o_uncorrectable),
        .o_pos(o_pos), .o_mag(o_mag), .o_overrun(o_overrun)
`ifdef RS_DEC_STATS_EN
        , .i_cnt_clr(i_cnt_clr), .o_cnt_corr(o_cnt_corr), .o_cnt_unc(o_cnt_unc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_done"}, 32'(o_done), 0);
        check({tag, "_flags"}, 32'({o_no_error, o_corrected, o_uncorrectable}), 0);
        check({tag, "_pos"}, 32'(o_pos), 0);
        check({tag, "_mag"}, 32'(o_mag), 0);
        check({tag, "_ovr"}, 32'(o_overrun), 0);
    endtask

    // pulse i_start for edge E0; caller then waits for the decision
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        @(negedge i_clk);
        i_s0 = a; i_s1 = b; i_s2 = c; i_s3 = d;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // flags are {no_error, corrected, uncorrectable}
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input int exp_lat,
                             input logic [2:0] exp_flags, input logic [4:0] exp_pos,
                             input logic [7:0] exp_mag);
        int lat;
        issue(a, b, c, d);
        check({tag, "_busy_e0"}, 32'(o_busy), 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_flags"}, 32'({o_no_error, o_corrected, o_uncorrectable}), 32'(exp_flags));
        check({tag, "_pos"}, 32'(o_pos), 32'(exp_pos));
        check({tag, "_mag"}, 32'(o_mag), 32'(exp_mag));
        check({tag, "_busy_done"}, 32'(o_busy), 0);
        @(posedge i_clk);
        #1;
        check({tag, "_done_pulse"}, 32'(o_done), 0);
        check({tag, "_hold"}, 32'({o_no_error, o_corrected, o_uncorrectable, o_pos, o_mag}),
              32'({exp_flags, exp_pos, exp_mag}));
    endtask

    initial begin
        i_res = 1'b1; i_start = 1'b0;
        i_s0 = '0; i_s1 = '0; i_s2 = '0; i_s3 = '0;
`ifdef RS_DEC_STATS_EN
        i_cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check_idle_outputs("reset");
        @(negedge i_clk);
        i_res = 1'b0;

        run_frame("clean",    8'h00, 8'h00, 8'h00, 8'h00, 1,  3'b100, 5'd0,  8'h00);
        run_frame("pos31",    8'h01, 8'h01, 8'h01, 8'h01, 1,  3'b010, 5'd31, 8'h01);
        run_frame("pos30",    8'h05, 8'h0A, 8'h14, 8'h28, 2,  3'b010, 5'd30, 8'h05);
        run_frame("pos23",    8'h01, 8'h1D, 8'h4C, 8'h8F, 9,  3'b010, 5'd23, 8'h01);
        run_frame("exhaust",  8'h01, 8'h02, 8'h01, 8'h01, 32, 3'b001, 5'd0,  8'h00);
        run_frame("s0zero",   8'h00, 8'h02, 8'h00, 8'h00, 1,  3'b001, 5'd0,  8'h00);

        // abort: restart sampled at E5 supersedes the first search
        issue(8'h01, 8'h02, 8'h01, 8'h01);
        for (int k = 1; k <= 4; k++) begin
            @(posedge i_clk);
            #1;
            check("abort_no_done", 32'(o_done), 0);
        end
        issue(8'h01, 8'h01, 8'h01, 8'h01);
        check("abort_overrun", 32'(o_overrun), 1);
        check("abort_done_e5", 32'(o_done), 0);
        check("abort_busy_e5", 32'(o_busy), 1);
        @(posedge i_clk);
        #1;
        check("abort_done_e6", 32'(o_done), 1);
        check("abort_ovr_pulse", 32'(o_overrun), 0);
        check("abort_result", 32'({o_corrected, o_pos, o_mag}), 32'({1'b1, 5'd31, 8'h01}));

        // reset in the middle of a search
        issue(8'h01, 8'h02, 8'h01, 8'h01);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_res = 1'b1;
        #1;
        check_idle_outputs("midres");
        @(negedge i_clk);
        i_res = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge i_clk);
            #1;
            if (o_done || o_busy) break;
        end
        check("midres_quiet", 32'({o_done, o_busy}), 0);

`ifdef RS_DEC_STATS_EN
        check("cnt_reset", 32'({o_cnt_corr, o_cnt_unc}), 0);
        run_frame("st_c1", 8'h01, 8'h01, 8'h01, 8'h01, 1,  3'b010, 5'd31, 8'h01);
        run_frame("st_c2", 8'h05, 8'h0A, 8'h14, 8'h28, 2,  3'b010, 5'd30, 8'h05);
        run_frame("st_u1", 8'h00, 8'h02, 8'h00, 8'h00, 1,  3'b001, 5'd0,  8'h00);
        run_frame("st_n",  8'h00, 8'h00, 8'h00, 8'h00, 1,  3'b100, 5'd0,  8'h00);
        run_frame("st_c3", 8'h01, 8'h1D, 8'h4C, 8'h8F, 9,  3'b010, 5'd23, 8'h01);
        check("cnt_corr", 32'(o_cnt_corr), 3);
        check("cnt_unc", 32'(o_cnt_unc), 1);
        @(negedge i_clk);
        i_cnt_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_cnt_clr = 1'b0;
        check("cnt_clear", 32'({o_cnt_corr, o_cnt_unc}), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
